// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side bus of the scoreboarded register file.
// Handshake: there is no per-transfer ready; wr_en/claim_en are single-cycle strobes that
// the file accepts on any rising edge while ready=1 and silently drops while ready=0.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic              ready;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, ready
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, ready
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with busy scoreboard, post-reset clearing sweep and hardwired-zero r0.
// Optional same-cycle write-through to the read ports: define REGFILE_WR_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  reg_file_sb_if.slave    bus,
  output logic            dbgState
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              memWe;
  logic [ADDR_W-1:0] memWaddr;
  logic [DATA_W-1:0] memWdata;
  logic [DEPTH-1:0]  busySet;
  logic [DEPTH-1:0]  busyClr;

  assign dbgState  = state;
  assign bus.ready = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
    end else begin
      state <= stateNext;
      if (state == CLEAR) cnt <= cnt + 1'b1;
      // Clear before set so a same-edge claim overrides the write's release.
      busy  <= (busy & ~busyClr) | busySet;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe && !rst) mem[memWaddr] <= memWdata;
  end

  always_comb begin
    stateNext = state;
    memWe     = 1'b0;
    memWaddr  = bus.wr_addr;
    memWdata  = bus.wr_data;
    busySet   = '0;
    busyClr   = '0;
    case (state)
      CLEAR: begin
        memWe    = 1'b1;
        memWaddr = cnt;
        memWdata = '0;
        if (cnt == LAST) stateNext = RUN;
      end
      RUN: begin
        if (bus.wr_en && bus.wr_addr != '0) begin
          memWe            = 1'b1;
          busyClr[bus.wr_addr] = 1'b1;
        end
        if (bus.claim_en && bus.claim_addr != '0) busySet[bus.claim_addr] = 1'b1;
      end
      default: stateNext = CLEAR;
    endcase
  end

  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              busy1;
  logic              busy2;

`ifdef REGFILE_WR_BYPASS_EN
  logic hit1;
  logic hit2;
  logic wrClaimed;

  always_comb begin
    hit1      = bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == bus.rd_addr1);
    hit2      = bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == bus.rd_addr2);
    wrClaimed = bus.claim_en && (bus.claim_addr == bus.wr_addr);
    data1     = hit1 ? bus.wr_data : mem[bus.rd_addr1];
    data2     = hit2 ? bus.wr_data : mem[bus.rd_addr2];
    busy1     = hit1 ? wrClaimed   : busy[bus.rd_addr1];
    busy2     = hit2 ? wrClaimed   : busy[bus.rd_addr2];
  end
`else
  always_comb begin
    data1 = mem[bus.rd_addr1];
    data2 = mem[bus.rd_addr2];
    busy1 = busy[bus.rd_addr1];
    busy2 = busy[bus.rd_addr2];
  end
`endif

  // Storage is undefined until the sweep finishes, so reads are forced to zero until then.
  assign bus.rd_data1 = (bus.ready && bus.rd_addr1 != '0) ? data1 : '0;
  assign bus.rd_data2 = (bus.ready && bus.rd_addr2 != '0) ? data2 : '0;
  assign bus.rd_busy1 = bus.ready && (bus.rd_addr1 != '0) && busy1;
  assign bus.rd_busy2 = bus.ready && (bus.rd_addr2 != '0) && busy2;
endmodule
